// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen native bus among several masters.
// Grant is registered and held until the downstream completes the access.
module rggen_bus_arbiter #(
   parameter int REQUESTERS    = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int STROBE_WIDTH  = BUS_WIDTH / 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [REQUESTERS-1:0]             i_valid,
   input  logic [2*REQUESTERS-1:0]           i_access,
   input  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_address,
   input  logic [BUS_WIDTH*REQUESTERS-1:0]   i_write_data,
   input  logic [STROBE_WIDTH*REQUESTERS-1:0] i_strobe,
   output logic [REQUESTERS-1:0]             o_ready,
   output logic [2*REQUESTERS-1:0]           o_status,
   output logic [BUS_WIDTH*REQUESTERS-1:0]   o_read_data,
   output logic [REQUESTERS-1:0]             o_grant,
   output logic                              o_bus_valid,
   output logic [1:0]                        o_bus_access,
   output logic [ADDRESS_WIDTH-1:0]          o_bus_address,
   output logic [BUS_WIDTH-1:0]              o_bus_write_data,
   output logic [STROBE_WIDTH-1:0]           o_bus_strobe,
   input  logic                              i_bus_ready,
   input  logic [1:0]                        i_bus_status,
   input  logic [BUS_WIDTH-1:0]              i_bus_read_data
);

   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [REQUESTERS-1:0] grant_q;
   logic [REQUESTERS-1:0] grant_d;
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         ptr_d;
   logic [PW-1:0]         gidx;
   logic [PW-1:0]         next_ptr;
   logic [REQUESTERS-1:0] pick;
   logic                  done;

   // First set bit of req, searching upward from start, wrapping around.
   function automatic logic [REQUESTERS-1:0] rr_pick(
      input logic [REQUESTERS-1:0] req,
      input logic [PW-1:0]         start
   );
      logic [REQUESTERS-1:0] win;
      logic                  found;
      int                    j;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         j = (int'(start) + i) % REQUESTERS;
         if (!found && req[j]) begin
            found  = 1'b1;
            win[j] = 1'b1;
         end
      end
      return win;
   endfunction

   always_comb begin
      gidx = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (grant_q[i]) gidx = PW'(i);
      end
   end

   assign next_ptr = (gidx == PW'(REQUESTERS - 1)) ? '0 : gidx + PW'(1);
   assign done     = (state_q == BUSY) && i_bus_ready;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      pick    = '0;
      unique case (state_q)
         IDLE: begin
            pick = rr_pick(i_valid, ptr_q);
            if (|pick) begin
               state_d = BUSY;
               grant_d = pick;
            end
         end
         BUSY: begin
            if (i_bus_ready) begin
               ptr_d = next_ptr;
               // The finishing master is excluded so others get the bus first.
               pick  = rr_pick(i_valid & ~grant_q, next_ptr);
               if (|pick) begin
                  grant_d = pick;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_bus_valid = (state_q == BUSY);

   always_comb begin
      o_bus_access     = '0;
      o_bus_address    = '0;
      o_bus_write_data = '0;
      o_bus_strobe     = '0;
      if (state_q == BUSY) begin
         o_bus_access     = i_access[2*gidx +: 2];
         o_bus_address    = i_address[ADDRESS_WIDTH*gidx +: ADDRESS_WIDTH];
         o_bus_write_data = i_write_data[BUS_WIDTH*gidx +: BUS_WIDTH];
         o_bus_strobe     = i_strobe[STROBE_WIDTH*gidx +: STROBE_WIDTH];
      end
   end

   always_comb begin
      o_ready     = '0;
      o_status    = '0;
      o_read_data = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (done && grant_q[k]) begin
            o_ready[k]                          = 1'b1;
            o_status[2*k +: 2]                  = i_bus_status;
            o_read_data[BUS_WIDTH*k +: BUS_WIDTH] = i_bus_read_data;
         end
      end
   end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter with three requesters.
// Responses are checked against a queue filled when the downstream answers.
module tb_rggen_bus_arbiter;

   localparam int N  = 3;
   localparam int AW = 8;
   localparam int BW = 32;
   localparam int SW = BW / 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    valid;
   logic [2*N-1:0]  access;
   logic [AW*N-1:0] address;
   logic [BW*N-1:0] wdata;
   logic [SW*N-1:0] strobe;
   logic [N-1:0]    ready;
   logic [2*N-1:0]  status;
   logic [BW*N-1:0] rdata;
   logic [N-1:0]    grant;
   logic            bus_valid;
   logic [1:0]      bus_access;
   logic [AW-1:0]   bus_address;
   logic [BW-1:0]   bus_wdata;
   logic [SW-1:0]   bus_strobe;
   logic            bus_ready;
   logic [1:0]      bus_status;
   logic [BW-1:0]   bus_rdata;

   logic [1:0]    req_acc [N];
   logic [AW-1:0] req_addr[N];
   logic [BW-1:0] req_wd  [N];
   logic [SW-1:0] req_st  [N];

   typedef struct {
      int          idx;
      logic [1:0]  st;
      logic [BW-1:0] rd;
   } exp_t;

   exp_t sbq[$];
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   always_comb begin
      access  = '0;
      address = '0;
      wdata   = '0;
      strobe  = '0;
      for (int k = 0; k < N; k++) begin
         access[2*k +: 2]    = req_acc[k];
         address[AW*k +: AW] = req_addr[k];
         wdata[BW*k +: BW]   = req_wd[k];
         strobe[SW*k +: SW]  = req_st[k];
      end
   end

   rggen_bus_arbiter #(
      .REQUESTERS   (N),
      .ADDRESS_WIDTH(AW),
      .BUS_WIDTH    (BW)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_valid         (valid),
      .i_access        (access),
      .i_address       (address),
      .i_write_data    (wdata),
      .i_strobe        (strobe),
      .o_ready         (ready),
      .o_status        (status),
      .o_read_data     (rdata),
      .o_grant         (grant),
      .o_bus_valid     (bus_valid),
      .o_bus_access    (bus_access),
      .o_bus_address   (bus_address),
      .o_bus_write_data(bus_wdata),
      .o_bus_strobe    (bus_strobe),
      .i_bus_ready     (bus_ready),
      .i_bus_status    (bus_status),
      .i_bus_read_data (bus_rdata)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus_ready  = 1'b0;
      bus_status = 2'b00;
      bus_rdata  = '0;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic respond(input int idx, input logic [1:0] st,
                          input logic [BW-1:0] rd);
      exp_t e;
      bus_ready  = 1'b1;
      bus_status = st;
      bus_rdata  = rd;
      e.idx = idx;
      e.st  = st;
      e.rd  = rd;
      sbq.push_back(e);
   endtask

   task automatic cyc_chk(input string tag, input logic [N-1:0] g);
      logic [1:0]    ea;
      logic [AW-1:0] ead;
      logic [BW-1:0] ewd;
      logic [SW-1:0] est;
      logic [N-1:0]  er;
      logic [2*N-1:0] es;
      logic [BW*N-1:0] ed;
      exp_t e;
      ea  = '0;
      ead = '0;
      ewd = '0;
      est = '0;
      for (int k = 0; k < N; k++) begin
         if (g[k]) begin
            ea  = req_acc[k];
            ead = req_addr[k];
            ewd = req_wd[k];
            est = req_st[k];
         end
      end
      chk({tag, "_grant"}, 128'(grant), 128'(g));
      chk({tag, "_bvalid"}, 128'(bus_valid), 128'(|g));
      chk({tag, "_baccess"}, 128'(bus_access), 128'(ea));
      chk({tag, "_baddr"}, 128'(bus_address), 128'(ead));
      chk({tag, "_bwdata"}, 128'(bus_wdata), 128'(ewd));
      chk({tag, "_bstrobe"}, 128'(bus_strobe), 128'(est));
      er = '0;
      es = '0;
      ed = '0;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         er[e.idx]         = 1'b1;
         es[2*e.idx +: 2]  = e.st;
         ed[BW*e.idx +: BW] = e.rd;
      end
      chk({tag, "_ready"}, 128'(ready), 128'(er));
      chk({tag, "_status"}, 128'(status), 128'(es));
      chk({tag, "_rdata"}, 128'(rdata), 128'(ed));
   endtask

   initial begin
      req_acc[0] = 2'b10; req_addr[0] = 8'h10;
      req_wd[0] = 32'h0000_0000; req_st[0] = 4'hf;
      req_acc[1] = 2'b11; req_addr[1] = 8'h24;
      req_wd[1] = 32'h1111_2222; req_st[1] = 4'h3;
      req_acc[2] = 2'b01; req_addr[2] = 8'h38;
      req_wd[2] = 32'h3333_4444; req_st[2] = 4'hc;
      rst        = 1'b1;
      valid      = '0;
      bus_ready  = 1'b0;
      bus_status = 2'b00;
      bus_rdata  = '0;

      step(); settle(); cyc_chk("rst", 3'b000);
      step(); rst = 1'b0; settle(); cyc_chk("rel", 3'b000);
      for (int i = 0; i < 10; i++) begin
         step();
         bus_ready  = i[0];
         bus_status = 2'b11;
         bus_rdata  = 32'hdead_beef;
         settle(); cyc_chk("idle", 3'b000);
      end

      step(); valid = 3'b001; settle(); cyc_chk("t2_req", 3'b000);
      step(); settle(); cyc_chk("t2_v", 3'b001);
      step(); settle(); cyc_chk("t2_w", 3'b001);
      step(); respond(0, 2'b00, 32'h1234_5678);
      settle(); cyc_chk("t2_c", 3'b001);
      step(); valid = 3'b000; settle(); cyc_chk("t2_i", 3'b000);

      step(); rst = 1'b1; settle(); cyc_chk("rp", 3'b000);
      step(); rst = 1'b0; valid = 3'b111;
      settle(); cyc_chk("t3_0", 3'b000);
      step(); respond(0, 2'b01, 32'h0000_00a0);
      settle(); cyc_chk("t3_g0", 3'b001);
      step(); respond(1, 2'b00, 32'h0000_00a1);
      settle(); cyc_chk("t3_g1", 3'b010);
      step(); respond(2, 2'b11, 32'h0000_00a2);
      settle(); cyc_chk("t3_g2", 3'b100);
      step(); valid = 3'b011; respond(0, 2'b00, 32'h0000_00a3);
      settle(); cyc_chk("t3_g3", 3'b001);

      step(); valid = 3'b010; settle(); cyc_chk("t4_a", 3'b010);
      step(); valid = 3'b110; settle(); cyc_chk("t4_b", 3'b010);
      step(); respond(1, 2'b10, 32'hcafe_0001);
      settle(); cyc_chk("t5_c", 3'b010);
      step(); valid = 3'b100; settle(); cyc_chk("t4_nb", 3'b100);
      step(); respond(2, 2'b00, 32'h0bad_f00d);
      settle(); cyc_chk("t4_c2", 3'b100);
      step(); valid = 3'b000; settle(); cyc_chk("t4_i", 3'b000);

      step(); valid = 3'b010; settle(); cyc_chk("t6_r", 3'b000);
      step(); settle(); cyc_chk("t6_g", 3'b010);
      step(); rst = 1'b1;
      bus_ready  = 1'b1;
      bus_status = 2'b11;
      bus_rdata  = 32'h5555_aaaa;
      settle(); cyc_chk("t6_rst", 3'b000);
      step(); rst = 1'b0; valid = 3'b011;
      settle(); cyc_chk("t6_i", 3'b000);
      step(); respond(0, 2'b00, 32'h7777_0000);
      settle(); cyc_chk("t6_g0", 3'b001);
      step(); valid = 3'b010; respond(1, 2'b01, 32'h7777_0001);
      settle(); cyc_chk("t6_g1", 3'b010);
      step(); valid = 3'b000; settle(); cyc_chk("t6_end", 3'b000);

      chk("sb_empty", 128'(sbq.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
